cmd_queue: RTL and testbench

CMD_QUEUE -- requirements
Module: cmd_queue

---
 rtl/cmd_queue.sv | 96 +++++++++
 tb/tb_cmd_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_queue.sv
// Host-to-command-processor word queue: DEPTH x 64 FIFO, first-word fall-through, one-cycle push-to-pop latency.
// Backpressure: host_ready drops when full, flushing or in reset; cmd side holds the head word until cmd_ready.
module cmd_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_valid,
  input  logic [63:0]   host_data,
  output logic          host_ready,
  output logic          cmd_valid,
  output logic [63:0]   cmd_data,
  input  logic          cmd_ready,
  input  logic          halted,
  input  logic          flush,
  output logic [AW:0]   level,
  output logic [63:0]   issued_count
);

  typedef enum logic [1:0] {RUN, HALT, FLUSH} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [63:0]     mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     level_q, level_d;
  logic [63:0]     issued_q, issued_d;
  logic            push, pop;

  assign host_ready   = !rst && (level_q != FULL_LVL) && !flush && (state_q != FLUSH);
  assign cmd_valid    = !rst && (level_q != '0) && (state_q == RUN);
  assign cmd_data     = mem_q[rptr_q];
  assign level        = level_q;
  assign issued_count = issued_q;

  // A pop offered in the flush cycle is discarded, so it never counts as issued.
  assign push = host_valid && host_ready;
  assign pop  = cmd_valid && cmd_ready && !flush;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    issued_d = issued_q;

    case (state_q)
      RUN:     if (flush) state_d = FLUSH; else if (halted) state_d = HALT;
      HALT:    if (flush) state_d = FLUSH; else if (!halted) state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop) begin
        rptr_d   = rptr_q + AW'(1);
        issued_d = issued_q + 64'd1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      issued_q <= issued_d;
    end
  end

  // Storage is not reset; push is already blocked during reset via host_ready.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= host_data;
  end

endmodule

// File: tb/tb_cmd_queue.sv
// Bench for cmd_queue: a queue-based reference model checked every cycle, directed scenarios with literal
// expectations, then randomized traffic including halt, flush and reset.
module tb_cmd_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst, host_valid, cmd_ready, halted, flush;
  logic [63:0]   host_data;
  logic          host_ready, cmd_valid;
  logic [63:0]   cmd_data, issued_count;
  logic [AW:0]   level;

  always #5 clk = ~clk;

  cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .halted(halted), .flush(flush),
    .level(level), .issued_count(issued_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: words in flight, mode (0 run, 1 halt, 2 flush), issued total.
  logic [63:0] mq[$];
  int          mstate = 0;
  logic [63:0] mcnt = 64'd0;
  logic        e_hr, e_cv;
  int          nxt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    e_hr = !rst && (mq.size() != DEPTH) && !flush && (mstate != 2);
    e_cv = !rst && (mq.size() != 0) && (mstate == 0);
    chk("host_ready", 64'(host_ready), 64'(e_hr));
    chk("cmd_valid", 64'(cmd_valid), 64'(e_cv));
    if (e_cv) chk("cmd_data", cmd_data, mq[0]);
    chk("level", 64'(level), 64'(mq.size()));
    chk("issued_count", issued_count, mcnt);

    if (rst) begin
      mq.delete();
      mstate = 0;
      mcnt   = 64'd0;
    end else begin
      nxt = (mstate == 2) ? 0 : (flush ? 2 : (halted ? 1 : 0));
      if (flush) begin
        mq.delete();
      end else begin
        if (e_cv && cmd_ready) begin
          void'(mq.pop_front());
          mcnt = mcnt + 64'd1;
        end
        if (e_hr && host_valid) mq.push_back(host_data);
      end
      mstate = nxt;
    end
  end

  task automatic step(input logic r, input logic hv, input logic [63:0] d,
                      input logic cr, input logic h, input logic f);
    @(posedge clk);
    #1;
    rst        = r;
    host_valid = hv;
    host_data  = d;
    cmd_ready  = cr;
    halted     = h;
    flush      = f;
    #1;
  endtask

  initial begin
    rst = 1'b1; host_valid = 1'b0; host_data = '0;
    cmd_ready = 1'b0; halted = 1'b0; flush = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    chk("rst_host_ready", 64'(host_ready), 64'd0);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);

    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_host_ready", 64'(host_ready), 64'd1);
    chk("post_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("post_rst_level", 64'(level), 64'd0);
    chk("post_rst_issued", issued_count, 64'd0);

    // Fill to full, then drain in order.
    for (int i = 0; i < 8; i++) step(0, 1, 64'h11 + 64'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("full_level", 64'(level), 64'd8);
    chk("full_host_ready", 64'(host_ready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("drain_valid", 64'(cmd_valid), 64'd1);
      chk("drain_data", cmd_data, 64'h11 + 64'(i));
    end
    step(0, 0, 0, 0, 0, 0);
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_issued", issued_count, 64'd8);

    // Single-word latency: no same-cycle bypass.
    step(0, 1, 64'hA, 1, 0, 0);
    chk("lat_no_bypass", 64'(cmd_valid), 64'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("lat_valid", 64'(cmd_valid), 64'd1);
    chk("lat_data", cmd_data, 64'hA);
    chk("lat_level", 64'(level), 64'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("lat_level_after", 64'(level), 64'd0);
    chk("lat_issued", issued_count, 64'd9);

    // Streaming push+pop across pointer wraps.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 64'h100 + 64'(i), 1, 0, 0);
      if (i > 0) begin
        chk("stream_level", 64'(level), 64'd1);
        chk("stream_data", cmd_data, 64'h100 + 64'(i - 1));
      end
    end
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("stream_level_end", 64'(level), 64'd0);
    chk("stream_issued", issued_count, 64'd29);

    // Halt with pushes still accepted.
    for (int i = 0; i < 3; i++) step(0, 1, 64'h200 + 64'(i), 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, (i < 2), 64'h203 + 64'(i), 0, 1, 0);
      if (i > 0) chk("halt_valid", 64'(cmd_valid), 64'd0);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("halt_exit_valid", 64'(cmd_valid), 64'd0);
    chk("halt_level", 64'(level), 64'd5);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("halt_out_valid", 64'(cmd_valid), 64'd1);
      chk("halt_out_data", cmd_data, 64'h200 + 64'(i));
    end
    step(0, 0, 0, 0, 0, 0);
    chk("halt_issued", issued_count, 64'd34);

    // Flush with concurrent push and pop offered.
    for (int i = 0; i < 6; i++) step(0, 1, 64'h300 + 64'(i), 0, 0, 0);
    step(0, 1, 64'hDEAD, 1, 0, 1);
    chk("flush_host_ready", 64'(host_ready), 64'd0);
    chk("flush_level_before", 64'(level), 64'd6);
    step(0, 0, 0, 0, 0, 0);
    chk("flush_level", 64'(level), 64'd0);
    chk("flushst_host_ready", 64'(host_ready), 64'd0);
    chk("flushst_valid", 64'(cmd_valid), 64'd0);
    chk("flush_issued", issued_count, 64'd34);
    step(0, 0, 0, 0, 0, 0);
    chk("post_flush_host_ready", 64'(host_ready), 64'd1);

    // Reset mid-stream.
    for (int i = 0; i < 4; i++) step(0, 1, 64'h400 + 64'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pre_rst_valid", 64'(cmd_valid), 64'd1);
    step(1, 0, 0, 1, 0, 0);
    chk("mid_rst_valid", 64'(cmd_valid), 64'd0);
    chk("mid_rst_host_ready", 64'(host_ready), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_issued", issued_count, 64'd0);
    chk("mid_rst_host_ready_after", 64'(host_ready), 64'd1);
    step(0, 1, 64'h55, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("mid_rst_run_valid", 64'(cmd_valid), 64'd1);
    chk("mid_rst_run_data", cmd_data, 64'h55);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 70),
           {$urandom, $urandom},
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 2));
    end

    step(0, 0, 0, 1, 0, 0);
    repeat (DEPTH + 2) step(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
